// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states,
// oversampling constants and 8N1 frame geometry.
package uart_pkg;

   // Receiver FSM states
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rxState_t;

   // Oversampling: 16 ticks per bit, start bit checked at its middle tick
   localparam int OS_RATE = 16;
   localparam int OS_MID  = 7;

   // 8N1 framing: start + 8 data + stop
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receiver: pop strobe, error clear, head byte
// and status flags. The master is the CPU bus logic, the slave the UART.
interface uart_rx_fifo_if;
   import uart_pkg::*;

   logic                 rd;
   logic                 clr_err;
   logic [DATA_BITS-1:0] rd_data;
   logic                 valid;
   logic                 full;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output rd, clr_err,
      input  rd_data, valid, full, frame_err, overrun
   );

   modport slave (
      input  rd, clr_err,
      output rd_data, valid, full, frame_err, overrun
   );

endinterface

// File: rtl/rx_fifo.sv
// Parameterised synchronous FIFO with show-ahead read: the head entry is
// always visible on rdata while valid is high, and rd advances to the next.
// Pointers carry an extra wrap bit so full and empty fall out of a compare.
module rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             valid,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_valid;
   logic             w_full;
   logic             w_doRd;
   logic             w_doWr;

   assign w_valid = (r_wrPtr != r_rdPtr);
   assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

   // A pop on an empty FIFO is ignored; a push into a full FIFO only goes
   // through when a pop frees the head slot in the same cycle.
   assign w_doRd = rd && w_valid;
   assign w_doWr = wr && (!w_full || w_doRd);

   assign valid = w_valid;
   assign full  = w_full;
   assign rdata = w_valid ? r_mem[r_rdPtr[AW-1:0]] : '0;

   // Storage array; contents need no reset because valid masks stale data
   always_ff @(posedge clk) begin
      if (w_doWr) begin
         r_mem[r_wrPtr[AW-1:0]] <= wdata;
      end
   end

   // Read and write pointers advance on accepted pops and pushes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doWr) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doRd) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receive front-end: synchronises the RX pin, recovers frames with
// 16x oversampling, buffers bytes in a show-ahead FIFO and keeps sticky
// framing-error and overrun flags for the status register.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 78,
   parameter int DEPTH    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   uart_rx_fifo_if.slave bus
);

   localparam int             DIV_W   = $clog2(BAUD_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
   localparam logic [3:0]     OS_LAST = 4'(OS_RATE - 1);
   localparam logic [3:0]     OS_HALF = 4'(OS_MID);
   localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

   logic                 r_rxMeta;
   logic                 r_rxS;
   logic [DIV_W-1:0]     r_divCnt;
   logic                 w_tick;

   rxState_t             r_state;
   rxState_t             w_nextState;
   logic [3:0]           r_osCnt;
   logic [3:0]           w_nextOs;
   logic [2:0]           r_bitCnt;
   logic [2:0]           w_nextBit;
   logic [DATA_BITS-1:0] r_shreg;
   logic [DATA_BITS-1:0] w_nextShreg;
   logic                 r_inBreak;
   logic                 w_nextInBreak;
   logic                 w_startDetect;
   logic                 w_push;
   logic                 w_setFrame;
   logic                 w_setOverrun;

   logic                 r_frameErr;
   logic                 r_overrun;
   logic                 w_fifoFull;
   logic                 w_fifoValid;
   logic [DATA_BITS-1:0] w_fifoData;
   logic                 w_canPush;

   assign w_tick = (r_divCnt == DIV_LAST);

   // A full FIFO can still take a byte if the CPU pops in the same cycle
   assign w_canPush = !w_fifoFull || bus.rd;

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rxMeta <= 1'b1;
         r_rxS    <= 1'b1;
      end else begin
         r_rxMeta <= rx;
         r_rxS    <= r_rxMeta;
      end
   end

   // Oversample tick divider, re-phased to the falling edge of a start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_divCnt <= '0;
      end else if (w_startDetect || w_tick) begin
         r_divCnt <= '0;
      end else begin
         r_divCnt <= r_divCnt + 1'b1;
      end
   end

   // Receiver FSM state, counters and shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_osCnt   <= '0;
         r_bitCnt  <= '0;
         r_shreg   <= '0;
         r_inBreak <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_osCnt   <= w_nextOs;
         r_bitCnt  <= w_nextBit;
         r_shreg   <= w_nextShreg;
         r_inBreak <= w_nextInBreak;
      end
   end

   // Next-state logic: verify start mid-bit, sample each data bit and the
   // stop bit on the last tick of its window, and sit out line breaks
   always_comb begin
      w_nextState   = r_state;
      w_nextOs      = r_osCnt;
      w_nextBit     = r_bitCnt;
      w_nextShreg   = r_shreg;
      w_nextInBreak = r_inBreak;
      w_startDetect = 1'b0;
      w_push        = 1'b0;
      w_setFrame    = 1'b0;
      w_setOverrun  = 1'b0;

      case (r_state)
         IDLE: begin
            w_nextOs      = '0;
            w_nextInBreak = 1'b0;
            if (!r_rxS) begin
               w_nextState   = START;
               w_startDetect = 1'b1;
            end
         end

         START: begin
            if (w_tick) begin
               if (r_osCnt == OS_HALF) begin
                  if (r_rxS) begin
                     w_nextState = IDLE;
                  end else begin
                     w_nextState = DATA;
                     w_nextOs    = '0;
                     w_nextBit   = '0;
                  end
               end else begin
                  w_nextOs = r_osCnt + 1'b1;
               end
            end
         end

         DATA: begin
            if (w_tick) begin
               w_nextOs = r_osCnt + 1'b1;
               if (r_osCnt == OS_LAST) begin
                  w_nextShreg = {r_rxS, r_shreg[DATA_BITS-1:1]};
                  if (r_bitCnt == BIT_LAST) begin
                     w_nextState = STOP;
                  end else begin
                     w_nextBit = r_bitCnt + 1'b1;
                  end
               end
            end
         end

         STOP: begin
            if (r_inBreak) begin
               if (r_rxS) begin
                  w_nextState   = IDLE;
                  w_nextInBreak = 1'b0;
               end
            end else if (w_tick) begin
               w_nextOs = r_osCnt + 1'b1;
               if (r_osCnt == OS_LAST) begin
                  if (r_rxS) begin
                     w_nextState = IDLE;
                     if (w_canPush) begin
                        w_push = 1'b1;
                     end else begin
                        w_setOverrun = 1'b1;
                     end
                  end else begin
                     w_setFrame    = 1'b1;
                     w_nextInBreak = 1'b1;
                  end
               end
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Sticky error flags; a new error in the clear cycle keeps the flag set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frameErr <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_setFrame) begin
            r_frameErr <= 1'b1;
         end else if (bus.clr_err) begin
            r_frameErr <= 1'b0;
         end
         if (w_setOverrun) begin
            r_overrun <= 1'b1;
         end else if (bus.clr_err) begin
            r_overrun <= 1'b0;
         end
      end
   end

   rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (w_push),
      .wdata (r_shreg),
      .rd    (bus.rd),
      .rdata (w_fifoData),
      .valid (w_fifoValid),
      .full  (w_fifoFull)
   );

   assign bus.rd_data   = w_fifoData;
   assign bus.valid     = w_fifoValid;
   assign bus.full      = w_fifoFull;
   assign bus.frame_err = r_frameErr;
   assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo with BAUD_DIV=4 and DEPTH=4. Expected bytes go
// into a scoreboard queue as frames are sent and are popped as the CPU side
// reads them back.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int BAUD_DIV = 4;
   localparam int DEPTH    = 4;
   localparam int BIT_CYC  = OS_RATE * BAUD_DIV;
   localparam int PUSH_CYC = 3 + 152 * BAUD_DIV;

   logic clk;
   logic reset;
   logic rx;

   uart_rx_fifo_if bus ();

   uart_rx_fifo #(
      .BAUD_DIV (BAUD_DIV),
      .DEPTH    (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .bus   (bus)
   );

   int         nChecks;
   int         nFail;
   logic [7:0] expQ [$];
   int         validAt;
   logic [7:0] popData;

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck run still terminates
   initial begin
      #(600000);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one 8N1 frame starting right after a falling clock edge. If popAt
   // is non-negative, rd is pulsed during that cycle of the frame and the head
   // byte seen then is kept in popData. validAt records the first frame cycle
   // at which valid is observed high.
   task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int popAt);
      logic bitVal;
      validAt = -1;
      for (int b = 0; b < FRAME_BITS; b++) begin
         if (b == 0)             bitVal = 1'b0;
         else if (b <= 8)        bitVal = data[b-1];
         else                    bitVal = stopBit;
         for (int c = 0; c < BIT_CYC; c++) begin
            int cyc;
            cyc = b * BIT_CYC + c;
            if (validAt < 0 && bus.valid === 1'b1) validAt = cyc;
            if (c == 0) rx = bitVal;
            if (cyc == popAt) begin
               popData = bus.rd_data;
               bus.rd  = 1'b1;
            end else begin
               bus.rd  = 1'b0;
            end
            @(negedge clk);
         end
      end
      bus.rd = 1'b0;
   endtask

   // Wait (bounded) for a byte, capture it and pulse rd once
   task automatic readByte(output logic [7:0] d, output bit ok);
      ok = 1'b0;
      d  = 8'h00;
      for (int i = 0; i < 2000; i++) begin
         if (bus.valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         d      = bus.rd_data;
         bus.rd = 1'b1;
         @(negedge clk);
         bus.rd = 1'b0;
      end
   endtask

   task automatic idle(input int cycles);
      rx = 1'b1;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic test_reset;
      reset       = 1'b1;
      rx          = 1'b1;
      bus.rd      = 1'b0;
      bus.clr_err = 1'b0;
      repeat (3) @(negedge clk);
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid); end
      nChecks++;
      if (bus.full !== 1'b0) begin nFail++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
      nChecks++;
      if (bus.rd_data !== 8'h00) begin nFail++; $display("[TB] FAIL reset_rd_data: got %02h expected 00", bus.rd_data); end
      nChecks++;
      if (bus.frame_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
      nChecks++;
      if (bus.overrun !== 1'b0) begin nFail++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
      reset = 1'b0;
      idle(BIT_CYC);
   endtask

   task automatic test_single_frame;
      logic [7:0] d;
      logic [7:0] exp;
      bit         ok;
      sendFrame(8'hA5, 1'b1, -1);
      expQ.push_back(8'hA5);
      nChecks++;
      if (validAt != PUSH_CYC) begin nFail++; $display("[TB] FAIL single_latency: valid at frame cycle %0d expected %0d", validAt, PUSH_CYC); end
      nChecks++;
      if (bus.rd_data !== 8'hA5) begin nFail++; $display("[TB] FAIL single_head: got %02h expected a5", bus.rd_data); end
      readByte(d, ok);
      exp = expQ.pop_front();
      nChecks++;
      if (!ok || d !== exp) begin nFail++; $display("[TB] FAIL single_read: got %02h ok=%0d expected %02h", d, ok, exp); end
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL single_valid_after_rd: got %b expected 0", bus.valid); end
      nChecks++;
      if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
         nFail++; $display("[TB] FAIL single_flags: got fe=%b ov=%b expected 0 0", bus.frame_err, bus.overrun);
      end
      idle(BIT_CYC);
   endtask

   task automatic test_glitch;
      logic [7:0] d;
      logic [7:0] exp;
      bit         ok;
      rx = 1'b0;
      repeat (3 * BAUD_DIV) @(negedge clk);
      idle(3 * BIT_CYC);
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL glitch_valid: got %b expected 0", bus.valid); end
      nChecks++;
      if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
         nFail++; $display("[TB] FAIL glitch_flags: got fe=%b ov=%b expected 0 0", bus.frame_err, bus.overrun);
      end
      sendFrame(8'h5A, 1'b1, -1);
      expQ.push_back(8'h5A);
      readByte(d, ok);
      exp = expQ.pop_front();
      nChecks++;
      if (!ok || d !== exp) begin nFail++; $display("[TB] FAIL glitch_next_frame: got %02h ok=%0d expected %02h", d, ok, exp); end
      idle(BIT_CYC);
   endtask

   task automatic test_frame_error;
      logic [7:0] d;
      logic [7:0] exp;
      bit         ok;
      sendFrame(8'h3C, 1'b0, -1);
      rx = 1'b0;
      repeat (40 * BAUD_DIV) @(negedge clk);
      idle(BIT_CYC);
      nChecks++;
      if (bus.frame_err !== 1'b1) begin nFail++; $display("[TB] FAIL frame_err_set: got %b expected 1", bus.frame_err); end
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL break_no_frame: valid got %b expected 0", bus.valid); end
      nChecks++;
      if (bus.overrun !== 1'b0) begin nFail++; $display("[TB] FAIL break_overrun: got %b expected 0", bus.overrun); end
      sendFrame(8'h11, 1'b1, -1);
      expQ.push_back(8'h11);
      readByte(d, ok);
      exp = expQ.pop_front();
      nChecks++;
      if (!ok || d !== exp) begin nFail++; $display("[TB] FAIL after_break_read: got %02h ok=%0d expected %02h", d, ok, exp); end
      nChecks++;
      if (bus.frame_err !== 1'b1) begin nFail++; $display("[TB] FAIL frame_err_sticky: got %b expected 1", bus.frame_err); end
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      nChecks++;
      if (bus.frame_err !== 1'b0) begin nFail++; $display("[TB] FAIL frame_err_clear: got %b expected 0", bus.frame_err); end
      idle(BIT_CYC);
   endtask

   task automatic test_overrun;
      logic [7:0] d;
      logic [7:0] exp;
      bit         ok;
      bit         expOverrun;
      expOverrun = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         sendFrame(8'(v), 1'b1, -1);
         if (expQ.size() < DEPTH) expQ.push_back(8'(v));
         else                     expOverrun = 1'b1;
      end
      idle(8);
      nChecks++;
      if (bus.full !== 1'b1) begin nFail++; $display("[TB] FAIL overrun_full: got %b expected 1", bus.full); end
      nChecks++;
      if (bus.overrun !== expOverrun) begin nFail++; $display("[TB] FAIL overrun_flag: got %b expected %b", bus.overrun, expOverrun); end
      for (int i = 0; i < DEPTH; i++) begin
         readByte(d, ok);
         exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
         nChecks++;
         if (!ok || d !== exp) begin nFail++; $display("[TB] FAIL overrun_read%0d: got %02h ok=%0d expected %02h", i, d, ok, exp); end
      end
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL overrun_drained: valid got %b expected 0", bus.valid); end
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      nChecks++;
      if (bus.overrun !== 1'b0) begin nFail++; $display("[TB] FAIL overrun_clear: got %b expected 0", bus.overrun); end
      idle(BIT_CYC);
   endtask

   task automatic test_back_to_back;
      logic [7:0] d;
      logic [7:0] exp;
      bit         ok;
      for (int v = 0; v < DEPTH; v++) begin
         sendFrame(8'h21 + 8'(v), 1'b1, -1);
         expQ.push_back(8'h21 + 8'(v));
      end
      nChecks++;
      if (bus.full !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_prefull: got %b expected 1", bus.full); end
      sendFrame(8'h25, 1'b1, PUSH_CYC - 1);
      exp = expQ.pop_front();
      expQ.push_back(8'h25);
      nChecks++;
      if (popData !== exp) begin nFail++; $display("[TB] FAIL b2b_pop_head: got %02h expected %02h", popData, exp); end
      nChecks++;
      if (bus.full !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_full: got %b expected 1", bus.full); end
      nChecks++;
      if (bus.overrun !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_overrun: got %b expected 0", bus.overrun); end
      for (int i = 0; i < DEPTH; i++) begin
         readByte(d, ok);
         exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
         nChecks++;
         if (!ok || d !== exp) begin nFail++; $display("[TB] FAIL b2b_read%0d: got %02h ok=%0d expected %02h", i, d, ok, exp); end
      end
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_drained: valid got %b expected 0", bus.valid); end
      idle(BIT_CYC);
   endtask

   task automatic test_reset_midframe;
      logic [7:0] d;
      logic [7:0] exp;
      logic [7:0] partial;
      bit         ok;
      sendFrame(8'h3C, 1'b0, -1);
      idle(BIT_CYC);
      sendFrame(8'h5A, 1'b1, -1);
      idle(BIT_CYC);
      partial = 8'h7E;
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         rx = partial[b];
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = partial[4];
      repeat (BIT_CYC / 2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_valid: got %b expected 0", bus.valid); end
      nChecks++;
      if (bus.rd_data !== 8'h00) begin nFail++; $display("[TB] FAIL midreset_rd_data: got %02h expected 00", bus.rd_data); end
      nChecks++;
      if (bus.frame_err !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_frame_err: got %b expected 0", bus.frame_err); end
      expQ.delete();
      @(negedge clk);
      reset = 1'b0;
      idle(2 * BIT_CYC);
      nChecks++;
      if (bus.valid !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_no_ghost: valid got %b expected 0", bus.valid); end
      sendFrame(8'hC3, 1'b1, -1);
      expQ.push_back(8'hC3);
      readByte(d, ok);
      exp = expQ.pop_front();
      nChecks++;
      if (!ok || d !== exp) begin nFail++; $display("[TB] FAIL midreset_next_frame: got %02h ok=%0d expected %02h", d, ok, exp); end
      nChecks++;
      if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
         nFail++; $display("[TB] FAIL midreset_flags: got fe=%b ov=%b expected 0 0", bus.frame_err, bus.overrun);
      end
   endtask

   // Run every scenario in sequence and report
   initial begin
      nChecks     = 0;
      nFail       = 0;
      reset       = 1'b1;
      rx          = 1'b1;
      bus.rd      = 1'b0;
      bus.clr_err = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front-end between the board `RX` pin and the 6502 test unit's UART read port. It synchronises the asynchronous line and recovers 8N1 frames with 16x oversampling. Received bytes go into a small show-ahead FIFO that the CPU-side bus logic drains with a one-cycle read strobe. Sticky framing and overrun flags are reported for the ACIA status register.

## Interface
- `BAUD_DIV`, 78: `clk` cycles per oversample tick; 78 gives 9600 baud at 12 MHz (0.16 % error). Legal range 2..1023.
- `DEPTH`, 16: FIFO entries; power of two, 2..64.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high.
  - Clears FSM, counters, FIFO pointers and flags.
  - Synchroniser flops reset to 1.
- `rx` in 1: raw serial line; asynchronous; idle high.
- `rd` in 1: pop strobe, one cycle per byte; ignored when `valid`=0.
- `clr_err` in 1: clears `frame_err` and `overrun`.
- `rd_data` out 8: FIFO head byte; valid while `valid`=1; reset 0x00.
- `valid` out 1: FIFO non-empty; reset 0.
- `full` out 1: FIFO holds `DEPTH` bytes; reset 0.
- `frame_err` out 1: sticky; stop bit sampled low; reset 0.
- `overrun` out 1: sticky; good byte dropped because FIFO full; reset 0.

## Operation
**Synchroniser**
- 2 flops; `rx_s` is the output.
- All decisions use `rx_s` only.

**Tick generator**
- `div_cnt` counts 0..`BAUD_DIV`-1.
- `tick` = (`div_cnt`==`BAUD_DIV`-1).
- `div_cnt` is forced to 0 on the IDLE→START transition, so sampling is phase-aligned to the start edge.

**FSM (IDLE, START, DATA, STOP)**
- `os_cnt` is a 4-bit tick counter; `bit_cnt` is a 3-bit bit counter.
- IDLE: `rx_s`==0 → START; `os_cnt`=0.
- START: on `tick`, `os_cnt`++.
  - At the tick where `os_cnt`==7 (mid start bit):
    - `rx_s`==1 → IDLE (glitch rejected, nothing logged).
    - Otherwise → DATA; `os_cnt`=0; `bit_cnt`=0.
- DATA: sample at the tick where `os_cnt`==15.
  - Shift into the MSB of `shreg`, so bytes arrive LSB first.
  - `bit_cnt`==7 → STOP; otherwise `bit_cnt`++.
- STOP: sample at the tick where `os_cnt`==15.
  - `rx_s`==1 and FIFO can accept → push `shreg`; → IDLE.
  - `rx_s`==1 and FIFO cannot accept → drop byte; set `overrun`; → IDLE.
  - `rx_s`==0 → discard byte; set `frame_err`; remain in STOP until `rx_s`==1, then → IDLE. A break never generates spurious frames.

**FIFO**
- Read/write pointers carry an extra wrap bit; full/empty come from a pointer compare.
- Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
- Pop when empty: ignored, pointers unchanged.
- Push when empty: `rd_data` shows the new byte the cycle after the push.

**Flags**
- `clr_err` and a new error in the same cycle: set wins.
- `reset` mid-frame: FSM returns to IDLE immediately and FIFO contents are lost. The next falling `rx_s` starts a new frame.

## Timing
- Start-bit mid sample: 8 ticks after start detect.
- Stop-bit sample: 152 ticks after start detect.
- Pin-to-sample latency: 2 cycles of synchroniser delay plus ~152·`BAUD_DIV` cycles.
- Push happens on the clock edge ending the stop-sample cycle T; `valid`/`rd_data` are updated at T+1.
- `rd` in cycle N: `rd_data` shows the next entry (or `valid` drops) at N+1.
- `full`, `valid`, `frame_err`, `overrun` are registered, with no combinational path from `rx`.
- Tolerates ±3 % baud mismatch.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum
  - `OS_RATE`=16 and `OS_MID`=7
  - the 8N1 frame bit count
- Sub-module `rx_fifo`: parameterised synchronous FIFO with show-ahead read.
  - Ports: `clk`, `reset`, `wr`, `wdata`, `rd`, `rdata`, `valid`, `full`.
  - Reusable for a future TX buffer.
- Synchroniser, tick generator and FSM stay in the top `uart_rx_fifo`.

## Test plan
All tests use `BAUD_DIV`=4 and `DEPTH`=4 for short runs.
- **Single frame:** send 0xA5, stop=1 → `valid`=1 with `rd_data`=0xA5 at T+1; no flags; pulse `rd` → `valid`=0 next cycle.
- **Glitch:** drive `rx` low for 3 ticks, then high → FSM back to IDLE; `valid` stays 0; no flags.
- **Framing error and break:**
  - Send 0x3C with stop=0, hold `rx` low for 40 ticks → `frame_err`=1; FIFO empty; no frame logged during the break.
  - Then send 0x11 → 0x11 received; `frame_err` still 1 until `clr_err`.
- **Overrun:** send 5 bytes 0x01..0x05 without `rd` → `full`=1, `overrun`=1; reads return 0x01..0x04, then `valid`=0.
- **Simultaneous push and pop:** FIFO full, `rd` pulsed in the push cycle → no overrun; order preserved; `full` stays 1.
- **Reset mid-frame:** assert `reset` in bit 4 of frame 0x7E → outputs at reset values; next frame 0xC3 received correctly.
